// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MDU_BUSY = 2'd2
  } ctrl_state_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_REG   = 2'd0,
    FWD_E_ALU = 2'd1,
    FWD_M_ALU = 2'd2,
    FWD_M_MEM = 2'd3
  } fwd_sel_t;

  // Write-back tap observed from a later pipeline stage
  typedef struct packed {
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] rn;
  } wb_tap_t;

  // Register 0 is hard-wired, so it never counts as a dependency
  function automatic logic reg_hit(input logic [REG_W-1:0] rn,
                                   input logic [REG_W-1:0] rs);
    return (rn == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> pipeline controller taps and stage-control bundle.
// master = datapath side, slave = controller side.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic             d_branch_taken;
  logic             e_wreg;
  logic             e_m2reg;
  logic [REG_W-1:0] e_rn;
  logic             e_mdu_start;
  logic             m_wreg;
  logic             m_m2reg;
  logic [REG_W-1:0] m_rn;
  logic             m_mem_req;
  logic             mem_ready;

  logic             f_stall;
  logic             d_stall;
  logic             e_stall;
  logic             m_stall;
  logic             d_bubble;
  logic             e_bubble;
  logic             m_bubble;
  logic             w_bubble;
  logic [FWD_W-1:0] fwda;
  logic [FWD_W-1:0] fwdb;
  logic             busy;

  modport master (
    output d_rs, d_rt, d_use_rs, d_use_rt, d_branch_taken,
           e_wreg, e_m2reg, e_rn, e_mdu_start,
           m_wreg, m_m2reg, m_rn, m_mem_req, mem_ready,
    input  f_stall, d_stall, e_stall, m_stall,
           d_bubble, e_bubble, m_bubble, w_bubble,
           fwda, fwdb, busy
  );

  modport slave (
    input  d_rs, d_rt, d_use_rs, d_use_rt, d_branch_taken,
           e_wreg, e_m2reg, e_rn, e_mdu_start,
           m_wreg, m_m2reg, m_rn, m_mem_req, mem_ready,
    output f_stall, d_stall, e_stall, m_stall,
           d_bubble, e_bubble, m_bubble, w_bubble,
           fwda, fwdb, busy
  );

endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// D-stage operand forwarding select for a single source register.
module pipeline_ctrl_fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  wb_tap_t          e_tap,
  input  wb_tap_t          m_tap,
  output fwd_sel_t         sel
);

  // A load in E has no data yet; it is covered by the load-use stall instead
  always_comb begin
    sel = FWD_REG;
    if (e_tap.wreg && !e_tap.m2reg && reg_hit(e_tap.rn, src)) begin
      sel = FWD_E_ALU;
    end else if (m_tap.wreg && reg_hit(m_tap.rn, src)) begin
      sel = m_tap.m2reg ? FWD_M_MEM : FWD_M_ALU;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing unit for the F/D/E/M/W pipeline: stalls, bubbles,
// forwarding selects, memory-wait and MDU sequencing. Macro: PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic            clk,
  input  logic            resetn,
  pipeline_ctrl_if.slave  pif
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  localparam int unsigned MDU_CNT_W = $clog2(MDU_LAT);
  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 2);

  ctrl_state_t          state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic                 resume_q, resume_d;

  logic     mdu_live;
  logic     run_live;
  logic     mem_hold;
  logic     mdu_begin;
  logic     mdu_cont;
  logic     mdu_hold;
  logic     load_use;
  wb_tap_t  e_tap;
  wb_tap_t  m_tap;
  fwd_sel_t fwda_sel;
  fwd_sel_t fwdb_sel;

  assign e_tap = '{wreg: pif.e_wreg, m2reg: pif.e_m2reg, rn: pif.e_rn};
  assign m_tap = '{wreg: pif.m_wreg, m2reg: pif.m_m2reg, rn: pif.m_rn};

  pipeline_ctrl_fwd_unit u_fwd_a (
    .src   (pif.d_rs),
    .e_tap (e_tap),
    .m_tap (m_tap),
    .sel   (fwda_sel)
  );

  pipeline_ctrl_fwd_unit u_fwd_b (
    .src   (pif.d_rt),
    .e_tap (e_tap),
    .m_tap (m_tap),
    .sel   (fwdb_sel)
  );

  assign pif.fwda = fwda_sel;
  assign pif.fwdb = fwdb_sel;

  // A miss frozen out of MDU_BUSY remembers that the MDU op must resume
  assign mdu_live  = (state_q == MDU_BUSY) || ((state_q == MEM_WAIT) && resume_q);
  assign run_live  = (state_q == RUN) || ((state_q == MEM_WAIT) && !resume_q);
  assign mem_hold  = !pif.mem_ready && ((state_q == MEM_WAIT) || pif.m_mem_req);
  assign mdu_begin = !mem_hold && run_live && pif.e_mdu_start;
  assign mdu_cont  = !mem_hold && mdu_live && (cnt_q != '0);
  assign mdu_hold  = mdu_begin || mdu_cont;

  assign load_use = pif.e_wreg && pif.e_m2reg &&
                    ((pif.d_use_rs && reg_hit(pif.e_rn, pif.d_rs)) ||
                     (pif.d_use_rt && reg_hit(pif.e_rn, pif.d_rt)));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  end

  // Next state: memory wait freezes everything, including the MDU count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;
    if (mem_hold) begin
      state_d  = MEM_WAIT;
      resume_d = mdu_live;
    end else if (mdu_begin) begin
      state_d  = MDU_BUSY;
      cnt_d    = CNT_LOAD;
      resume_d = 1'b0;
    end else if (mdu_cont) begin
      state_d  = MDU_BUSY;
      cnt_d    = cnt_q - MDU_CNT_W'(1);
      resume_d = 1'b0;
    end else begin
      state_d  = RUN;
      cnt_d    = '0;
      resume_d = 1'b0;
    end
  end

  // Stage controls; priority memory wait > MDU > load-use > branch flush
  always_comb begin
    pif.f_stall  = 1'b0;
    pif.d_stall  = 1'b0;
    pif.e_stall  = 1'b0;
    pif.m_stall  = 1'b0;
    pif.d_bubble = 1'b0;
    pif.e_bubble = 1'b0;
    pif.m_bubble = 1'b0;
    pif.w_bubble = 1'b0;
    pif.busy     = (state_q != RUN);
    if (resetn) begin
      if (mem_hold) begin
        pif.f_stall  = 1'b1;
        pif.d_stall  = 1'b1;
        pif.e_stall  = 1'b1;
        pif.m_stall  = 1'b1;
        pif.w_bubble = 1'b1;
      end else if (mdu_hold) begin
        pif.f_stall  = 1'b1;
        pif.d_stall  = 1'b1;
        pif.e_stall  = 1'b1;
        pif.m_bubble = 1'b1;
      end else if (load_use) begin
        pif.f_stall  = 1'b1;
        pif.d_stall  = 1'b1;
        pif.e_bubble = 1'b1;
      end else if (pif.d_branch_taken) begin
        pif.d_bubble = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating stall/flush event counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (pif.f_stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (pif.d_bubble && (flush_cycles != '1)) begin
        flush_cycles <= flush_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing unit for the 5-stage pipeline (F/D/E/M/W).
- Drives the stall/bubble inputs of every pipeline_reg stage.
- Generates D-stage operand forwarding selects.
- Sequences multi-cycle events: data-memory wait handshake and the multi-cycle multiply/divide unit (MDU).
- Sits beside the datapath and observes register-number/control taps from the D, E and M stages.

Parameters:
MDU_LAT, 4, total E-stage occupancy of an MDU op in cycles (>=2)
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
d_rs  in  5  D-stage source register A
d_rt  in  5  D-stage source register B
d_use_rs  in  1  D instruction reads rs
d_use_rt  in  1  D instruction reads rt
d_branch_taken  in  1  branch/jump resolved taken in D
e_wreg  in  1  E writes register file
e_m2reg  in  1  E is a load
e_rn  in  5  E destination register
e_mdu_start  in  1  E holds an MDU op (level, valid while in E)
m_wreg  in  1  M writes register file
m_m2reg  in  1  M is a load
m_rn  in  5  M destination register
m_mem_req  in  1  M performs a memory access
mem_ready  in  1  memory completes M access this cycle
f_stall, d_stall, e_stall, m_stall  out  1 each  hold stage register
d_bubble, e_bubble, m_bubble, w_bubble  out  1 each  insert bubble into stage register
fwda  out  2  rs source: 0 regfile, 1 E ALU, 2 M ALU, 3 M memory data
fwdb  out  2  rt source, same encoding
busy  out  1  FSM not in RUN

Behaviour:
- FSM states: RUN, MEM_WAIT, MDU_BUSY. Registered state; MDU down-counter cnt, width clog2(MDU_LAT).
- Reset (resetn=0, async): state=RUN, cnt=0. All stall/bubble outputs are combinational from registered state and inputs; with no hazard they are 0.
- Forwarding (combinational, rs shown, rt identical):
  - E match (e_wreg, !e_m2reg, e_rn==d_rs, d_rs!=0) -> 1.
  - Else M match: m_m2reg -> 3, otherwise -> 2.
  - Else 0.
  - Register 0 never forwards.
- Load-use: e_wreg & e_m2reg & e_rn!=0 & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt)) -> f_stall=d_stall=1, e_bubble=1. One cycle; on the next cycle the load is in M and forwarding selects 3.
- Branch: d_branch_taken and no load-use -> d_bubble=1 (flush F->D slot). Load-use suppresses the branch flush, since the branch is recomputed next cycle.
- RUN -> MEM_WAIT: m_mem_req & !mem_ready.
  - In MEM_WAIT and on the entry cycle: f/d/e/m_stall=1, w_bubble=1.
  - Exit to RUN the cycle mem_ready=1. The stall is deasserted in that same cycle, so zero extra latency.
- RUN -> MDU_BUSY: e_mdu_start & not in memory wait. cnt loads MDU_LAT-2.
  - On the entry cycle and while busy: f/d/e_stall=1, m_bubble=1.
  - At cnt==0 return to RUN, stall released. The MDU op occupies E exactly MDU_LAT cycles.
- Priority: MEM_WAIT > MDU_BUSY > load-use > branch.
  - An m_mem_req miss arriving while MDU_BUSY freezes all stages (mem rules); cnt holds.
  - MDU_BUSY resumes when mem_ready arrives.
  - A stalled stage never simultaneously receives a bubble, except the downstream bubble listed above.
- Reset mid-MEM_WAIT or mid-MDU_BUSY: immediate return to RUN, cnt=0, no outputs asserted.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs stall_cycles, flush_cycles (CNT_W each).
  - stall_cycles increments on any cycle f_stall=1.
  - flush_cycles increments on any cycle d_bubble=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: no ports, no counters.

Decomposition:
- Package pipeline_ctrl_pkg: enum ctrl_state_t {RUN, MEM_WAIT, MDU_BUSY}, fwd_sel_t constants FWD_REG/FWD_E_ALU/FWD_M_ALU/FWD_M_MEM.
- Sub-module fwd_unit: combinational forwarding for one operand, instantiated twice.

Test Plan:
- Load r5 in E, D reads r5 as rs -> one cycle f_stall=d_stall=e_bubble=1, next cycle fwda=3, no stall.
- ALU writes r3 in E and D reads r3 as rt -> fwdb=1. Same with write to r0 -> fwdb=0.
- m_mem_req=1, mem_ready low 3 cycles -> f/d/e/m_stall=1, w_bubble=1 for exactly 3 cycles, busy=1. Released the cycle mem_ready rises.
- e_mdu_start with MDU_LAT=4 -> f/d/e_stall=1, m_bubble=1 for 3 cycles, then RUN. Miss injected mid-op extends total stall by the miss length.
- d_branch_taken with concurrent load-use -> d_bubble=0, load-use stall taken. Next cycle, branch alone -> d_bubble=1.
- resetn asserted during MEM_WAIT -> busy=0 and all stall/bubble outputs 0 asynchronously. With PIPE_CTRL_PERF_EN, counters read 0.
